// File: rtl/multiplier_taint_word.sv
// Constant-time shift-add unsigned multiplier with word-level taint tracking.
// Latency from an accepted start to a registered product is always NUM_BITS+2 edges.
module multiplier_taint_word #(
    parameter int NUM_BITS = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_BITS-1:0]     multiplier,
    input  logic [NUM_BITS-1:0]     multiplicand,
    input  logic                    start_t,
    input  logic                    multiplier_t,
    input  logic                    multiplicand_t,
    output logic [2*NUM_BITS-1:0]   product,
    output logic                    product_t,
    output logic                    state_t
);

    localparam int PW = 2 * NUM_BITS;
    localparam int CW = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        CALC,
        DONE
    } state_e;

    state_e state;
    state_e next_state;

    logic [PW-1:0]        a_reg;
    logic [NUM_BITS-1:0]  b_reg;
    logic [PW-1:0]        acc;
    logic [CW-1:0]        count;
    logic                 op_t;

    logic track_start_t;
    logic load_ops;
    logic clear_acc;
    logic do_step;
    logic write_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // CALC exits on the step counter alone, so operand values never steer control flow.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = INIT;
                end
            end
            INIT: begin
                next_state = CALC;
            end
            CALC: begin
                if (count == LAST_STEP) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        track_start_t = 1'b0;
        load_ops      = 1'b0;
        clear_acc     = 1'b0;
        do_step       = 1'b0;
        write_result  = 1'b0;
        case (state)
            IDLE: begin
                track_start_t = 1'b1;
                load_ops      = start;
            end
            INIT: begin
                clear_acc = 1'b1;
            end
            CALC: begin
                do_step = 1'b1;
            end
            DONE: begin
                write_result = 1'b1;
            end
            default: begin
                track_start_t = 1'b0;
            end
        endcase
    end

    // The branch on start is evaluated in every IDLE cycle, so its taint sticks to the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            count     <= '0;
            op_t      <= 1'b0;
            state_t   <= 1'b0;
            product   <= '0;
            product_t <= 1'b0;
        end else begin
            if (track_start_t) begin
                state_t <= state_t | start_t;
            end
            if (load_ops) begin
                b_reg <= multiplier;
                a_reg <= {{NUM_BITS{1'b0}}, multiplicand};
                op_t  <= multiplier_t | multiplicand_t;
            end
            if (clear_acc) begin
                acc   <= '0;
                count <= '0;
            end
            if (do_step) begin
                acc   <= acc + (a_reg & {PW{b_reg[0]}});
                a_reg <= a_reg << 1;
                b_reg <= b_reg >> 1;
                count <= count + CW'(1);
            end
            if (write_result) begin
                product   <= acc;
                product_t <= op_t | state_t;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_taint_word.sv
// Self-checking bench for multiplier_taint_word: scoreboard of expected products,
// exact-latency checks, taint propagation and mid-operation reset.
module tb_multiplier_taint_word;

    localparam int N  = 7;
    localparam int PW = 2 * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  multiplier = '0;
    logic [N-1:0]  multiplicand = '0;
    logic          start_t = 1'b0;
    logic          multiplier_t = 1'b0;
    logic          multiplicand_t = 1'b0;
    logic [PW-1:0] product;
    logic          product_t;
    logic          state_t;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [PW-1:0] p;
        logic          pt;
        logic          st;
    } exp_t;

    exp_t          sb[$];
    logic [PW-1:0] exp_prev = '0;
    logic          exp_state_t = 1'b0;

    multiplier_taint_word #(.NUM_BITS(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .multiplier     (multiplier),
        .multiplicand   (multiplicand),
        .start_t        (start_t),
        .multiplier_t   (multiplier_t),
        .multiplicand_t (multiplicand_t),
        .product        (product),
        .product_t      (product_t),
        .state_t        (state_t)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        start_t = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_prev    = '0;
        exp_state_t = 1'b0;
        sb.delete();
    endtask

    // mode 0: single-cycle start pulse; mode 1: toggle start/start_t while busy
    task automatic run_op(input logic [N-1:0] mcand, input logic [N-1:0] mplier,
                          input logic mcand_tt, input logic mplier_tt, input logic s_t,
                          input int mode, input string name);
        exp_t e;
        multiplicand   = mcand;
        multiplier     = mplier;
        multiplicand_t = mcand_tt;
        multiplier_t   = mplier_tt;
        start          = 1'b1;
        start_t        = s_t;
        exp_state_t    = exp_state_t | s_t;
        e.p  = {{N{1'b0}}, mcand} * {{N{1'b0}}, mplier};
        e.pt = mcand_tt | mplier_tt | exp_state_t;
        e.st = exp_state_t;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        multiplicand   = N'($urandom);
        multiplier     = N'($urandom);
        multiplicand_t = 1'b1;
        multiplier_t   = 1'b1;
        start          = (mode == 1);
        start_t        = (mode == 1);
        for (int i = 1; i <= N + 1; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (product !== exp_prev) begin
                bad++;
                $display("[TB] FAIL %s hold at edge k+%0d: product=%0d expected=%0d",
                         name, i, product, exp_prev);
            end
            if (mode == 1) begin
                start   = ~start;
                start_t = ~start_t;
            end
        end
        @(posedge clk);
        @(negedge clk);
        start          = 1'b0;
        start_t        = 1'b0;
        multiplicand_t = 1'b0;
        multiplier_t   = 1'b0;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("[TB] FAIL %s scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if (product !== e.p) begin
                bad++;
                $display("[TB] FAIL %s product: got=%0d expected=%0d", name, product, e.p);
            end
            total++;
            if (product_t !== e.pt) begin
                bad++;
                $display("[TB] FAIL %s product_t: got=%b expected=%b", name, product_t, e.pt);
            end
            total++;
            if (state_t !== e.st) begin
                bad++;
                $display("[TB] FAIL %s state_t: got=%b expected=%b", name, state_t, e.st);
            end
            exp_prev = e.p;
        end
    endtask

    task automatic check_cleared(input string name);
        total++;
        if (product !== '0) begin
            bad++;
            $display("[TB] FAIL %s product: got=%0d expected=0", name, product);
        end
        total++;
        if (product_t !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s product_t: got=%b expected=0", name, product_t);
        end
        total++;
        if (state_t !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s state_t: got=%b expected=0", name, state_t);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_cleared("reset");
    endtask

    task automatic test_multiply();
        run_op(7'd15, 7'd15, 1'b0, 1'b0, 1'b0, 0, "15x15");
        run_op(7'd0,  7'd12, 1'b0, 1'b0, 1'b0, 0, "0x12");
        run_op(7'd1,  7'd2,  1'b0, 1'b0, 1'b0, 0, "1x2");
        run_op(7'd0,  7'd0,  1'b0, 1'b0, 1'b0, 0, "0x0");
        run_op(7'd92, 7'd75, 1'b0, 1'b0, 1'b0, 0, "92x75");
        run_op(7'd42, 7'd78, 1'b0, 1'b0, 1'b0, 0, "42x78");
    endtask

    task automatic test_random();
        logic [N-1:0] a;
        logic [N-1:0] b;
        for (int i = 0; i < 6; i++) begin
            a = N'($urandom_range(1, 127));
            b = N'($urandom_range(1, 127));
            run_op(a, b, 1'b0, 1'b0, 1'b0, 0, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_op(7'd127, 7'd127, 1'b0, 1'b0, 1'b0, 0, "max");
        run_op(7'd0,   7'd99,  1'b0, 1'b0, 1'b0, 0, "0xX");
        run_op(7'd127, 7'd1,   1'b0, 1'b0, 1'b0, 0, "127x1");
    endtask

    task automatic test_reset_mid();
        multiplicand = 7'd100;
        multiplier   = 7'd100;
        start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        total++;
        if (product !== exp_prev) begin
            bad++;
            $display("[TB] FAIL mid_reset pre-hold: product=%0d expected=%0d", product, exp_prev);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_prev = '0;
        check_cleared("mid_reset");
        run_op(7'd11, 7'd13, 1'b0, 1'b0, 1'b0, 0, "after_mid_reset");
    endtask

    task automatic test_ignored_start();
        run_op(7'd33, 7'd21, 1'b0, 1'b0, 1'b0, 1, "toggle_start");
        run_op(7'd5,  7'd9,  1'b0, 1'b0, 1'b0, 0, "after_toggle");
    endtask

    task automatic test_taint();
        do_reset();
        run_op(7'd127, 7'd127, 1'b1, 1'b0, 1'b0, 0, "taint_operand");
        do_reset();
        run_op(7'd5, 7'd6, 1'b0, 1'b0, 1'b1, 0, "taint_start");
        run_op(7'd3, 7'd4, 1'b0, 1'b0, 1'b0, 0, "taint_sticky");
        do_reset();
        check_cleared("taint_cleared");
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_ignored_start();
        test_taint();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
